sm4_key_cache_ctrl: RTL and testbench

Four-entry, fully associative cache controller for expanded SM4 key material, indexed by a key-ID tag. It sits directly upstream of the 4-way LRU recorder. Lookup hits drive the recorder's first access port, refills drive its second access port, and the recorder's `replace_which` output selects the victim on a miss. Misses are forwarded to the key-expansion unit over a request/fill interface.

---
 rtl/sm4_key_cache_ctrl.sv | 170 +++++++++++++++++
 tb/tb_sm4_key_cache_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sm4_key_cache_ctrl.sv
// sm4_key_cache_ctrl
//   Four-entry fully associative cache for expanded SM4 key material,
//   looked up by key-ID tag. Hits are answered from local storage, and
//   misses are forwarded to the key-expansion unit and refilled into a victim way.
//   The controller drives the access ports of a downstream 4-way LRU recorder
//   and takes its victim choice from that recorder.
//
// Ports
//   clk_i, reset_i          clock, asynchronous active-high reset
//   req_v_i/req_tag_i       lookup request, accepted when req_ready_o is high
//   resp_*                  response channel (data, hit flag) to the consumer
//   miss_v_o/miss_tag_o     refill request to the expansion unit (miss_ready_i)
//   fill_v_i/fill_data_i    refill data pulse from the expansion unit
//   inval_i                 invalidate all entries
//   lru_hit_*/lru_fill_*    recorder access-1 (hits) / access-2 (refills)
//   replace_which_i         recorder victim choice
//   state_dbg_o             current FSM state, for observation only
//
// Handshakes: every channel transfers on the cycle where its valid and its
// ready are both high at the rising clock edge. A valid source holds its
// payload stable until that cycle. The one exception is fill_v_i. It is a
// single-cycle pulse without a ready, and it is honoured only in WAIT_FILL.

module sm4_key_cache_ctrl #(
  parameter int TAG_W  = 8,
  parameter int DATA_W = 128
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_v_i,
  input  logic [TAG_W-1:0]  req_tag_i,
  output logic              req_ready_o,
  output logic              resp_v_o,
  output logic [DATA_W-1:0] resp_data_o,
  output logic              resp_hit_o,
  input  logic              resp_ready_i,
  output logic              miss_v_o,
  output logic [TAG_W-1:0]  miss_tag_o,
  input  logic              miss_ready_i,
  input  logic              fill_v_i,
  input  logic [DATA_W-1:0] fill_data_i,
  input  logic              inval_i,
  output logic              lru_hit_v_o,
  output logic [1:0]        lru_hit_way_o,
  output logic              lru_fill_v_o,
  output logic [1:0]        lru_fill_way_o,
  input  logic [1:0]        replace_which_i,
  output logic [1:0]        state_dbg_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MISS_REQ  = 2'd1,
    WAIT_FILL = 2'd2,
    RESP      = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [3:0]        valid_q;
  logic [TAG_W-1:0]  tag_q  [4];
  logic [DATA_W-1:0] data_q [4];
  logic [TAG_W-1:0]  miss_tag_q;
  logic [DATA_W-1:0] resp_data_q;
  logic              resp_hit_q;

  logic [3:0] match;
  logic       hit;
  logic [1:0] hit_way;
  logic       has_invalid;
  logic [1:0] victim;
  logic       accept;
  logic       fill_fire;

  // Tag compare over valid entries. At most one entry can match, because an
  // entry is written only after a confirmed miss on that same tag.
  always_comb begin
    match   = '0;
    hit_way = 2'd0;
    for (int e = 0; e < 4; e++) begin
      match[e] = valid_q[e] && (tag_q[e] == req_tag_i);
    end
    for (int e = 3; e >= 0; e--) begin
      if (match[e]) hit_way = e[1:0];
    end
  end
  assign hit = |match;

  // The lowest invalid entry is preferred. The recorder's choice is used only
  // when the cache is full. Victim uses the pre-invalidate valid bits. A
  // same-cycle inval_i still leaves only the filled way valid.
  always_comb begin
    has_invalid = 1'b0;
    victim      = replace_which_i;
    for (int e = 3; e >= 0; e--) begin
      if (!valid_q[e]) begin
        has_invalid = 1'b1;
        victim      = e[1:0];
      end
    end
    if (!has_invalid) victim = replace_which_i;
  end

  assign accept    = (state_q == IDLE) && req_v_i;
  assign fill_fire = (state_q == WAIT_FILL) && fill_v_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (req_v_i) state_d = hit ? RESP : MISS_REQ;
      MISS_REQ:  if (miss_ready_i) state_d = WAIT_FILL;
      WAIT_FILL: if (fill_v_i) state_d = RESP;
      RESP:      if (resp_ready_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q     <= '0;
      miss_tag_q  <= '0;
      resp_data_q <= '0;
      resp_hit_q  <= 1'b0;
      for (int e = 0; e < 4; e++) begin
        tag_q[e]  <= '0;
        data_q[e] <= '0;
      end
    end else begin
      if (accept) begin
        if (hit) begin
          resp_data_q <= data_q[hit_way];
          resp_hit_q  <= 1'b1;
        end else begin
          miss_tag_q <= req_tag_i;
        end
      end
      if (fill_fire) begin
        tag_q[victim]  <= miss_tag_q;
        data_q[victim] <= fill_data_i;
        resp_data_q    <= fill_data_i;
        resp_hit_q     <= 1'b0;
      end
      // Clear first, then set the filled way. The later assignment wins for that bit.
      if (inval_i)   valid_q         <= '0;
      if (fill_fire) valid_q[victim] <= 1'b1;
    end
  end

  assign req_ready_o    = (state_q == IDLE);
  assign miss_v_o       = (state_q == MISS_REQ);
  assign resp_v_o       = (state_q == RESP);
  assign miss_tag_o     = miss_tag_q;
  assign resp_data_o    = resp_data_q;
  assign resp_hit_o     = resp_hit_q;

  // Recorder pulses are combinational so the recorder updates on the same edge.
  // The two pulses come from different states and cannot coincide.
  assign lru_hit_v_o    = accept && hit;
  assign lru_hit_way_o  = (accept && hit) ? hit_way : 2'd0;
  assign lru_fill_v_o   = fill_fire;
  assign lru_fill_way_o = fill_fire ? victim : 2'd0;

  assign state_dbg_o    = state_q;

endmodule

// File: tb/tb_sm4_key_cache_ctrl.sv
// Testbench for sm4_key_cache_ctrl. Directed lookups are driven with
// hand-computed expected responses, recorder pulses and refill tags. Monitors
// on the falling edge pop these and compare them against the DUT outputs.

module tb_sm4_key_cache_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_v = 1'b0;
  logic [7:0]   req_tag = '0;
  logic         req_ready;
  logic         resp_v;
  logic [127:0] resp_data;
  logic         resp_hit;
  logic         resp_ready = 1'b0;
  logic         miss_v;
  logic [7:0]   miss_tag;
  logic         miss_ready = 1'b0;
  logic         fill_v = 1'b0;
  logic [127:0] fill_data = '0;
  logic         inval = 1'b0;
  logic         lru_hit_v;
  logic [1:0]   lru_hit_way;
  logic         lru_fill_v;
  logic [1:0]   lru_fill_way;
  logic [1:0]   replace_which = '0;
  logic [1:0]   state_dbg;

  int n_vec = 0;
  int n_err = 0;

  logic [128:0] exp_resp_q[$];  // {hit, data}
  logic [2:0]   exp_lru_q[$];   // {is_fill, way}
  logic [7:0]   exp_miss_q[$];

  localparam logic [127:0] DATA_A = 128'h00112233445566778899aabbccddeeff;

  sm4_key_cache_ctrl #(.TAG_W(8), .DATA_W(128)) dut (
    .clk_i(clk), .reset_i(rst),
    .req_v_i(req_v), .req_tag_i(req_tag), .req_ready_o(req_ready),
    .resp_v_o(resp_v), .resp_data_o(resp_data), .resp_hit_o(resp_hit),
    .resp_ready_i(resp_ready),
    .miss_v_o(miss_v), .miss_tag_o(miss_tag), .miss_ready_i(miss_ready),
    .fill_v_i(fill_v), .fill_data_i(fill_data), .inval_i(inval),
    .lru_hit_v_o(lru_hit_v), .lru_hit_way_o(lru_hit_way),
    .lru_fill_v_o(lru_fill_v), .lru_fill_way_o(lru_fill_way),
    .replace_which_i(replace_which), .state_dbg_o(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [128:0] act, input logic [128:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mkd(input logic [7:0] t);
    return {16{t}};
  endfunction

  // Scoreboard monitors: sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (resp_v && resp_ready) begin
        if (exp_resp_q.size() == 0) chk("resp_unexpected", 129'd1, 129'd0);
        else chk("resp", {resp_hit, resp_data}, exp_resp_q.pop_front());
      end
      if (miss_v && miss_ready) begin
        if (exp_miss_q.size() == 0) chk("miss_unexpected", 129'd1, 129'd0);
        else chk("miss_tag", {121'd0, miss_tag}, {121'd0, exp_miss_q.pop_front()});
      end
      if (lru_hit_v && lru_fill_v) begin
        chk("lru_both", 129'd1, 129'd0);
      end else if (lru_hit_v || lru_fill_v) begin
        if (exp_lru_q.size() == 0) chk("lru_unexpected", 129'd1, 129'd0);
        else chk("lru", {126'd0, lru_fill_v, lru_hit_v ? lru_hit_way : lru_fill_way},
                 {126'd0, exp_lru_q.pop_front()});
      end
    end
  end

  // ---------------- driver ----------------
  // One lookup. A miss gets an optional refill-request stall, then a fill with the
  // given recorder choice and optional same-cycle invalidate. The response is
  // held for rstall cycles before it is accepted.
  task automatic do_req(input logic [7:0] t, input logic exp_hit, input logic [127:0] d,
                        input logic [1:0] way, input logic [1:0] repl,
                        input int mstall, input int rstall, input logic inv_fill);
    exp_resp_q.push_back({exp_hit, d});
    exp_lru_q.push_back({~exp_hit, way});
    if (!exp_hit) exp_miss_q.push_back(t);
    chk("req_ready_idle", {128'd0, req_ready}, 129'd1);
    req_v = 1'b1; req_tag = t;
    @(posedge clk); #1;
    req_v = 1'b0;
    chk("resp_v_latency", {128'd0, resp_v}, {128'd0, exp_hit});
    chk("miss_v_latency", {128'd0, miss_v}, {128'd0, ~exp_hit});
    if (!exp_hit) begin
      for (int i = 0; i < mstall; i++) begin
        if (i == 2) begin fill_v = 1'b1; fill_data = '1; end
        @(posedge clk); #1;
        fill_v = 1'b0;
        chk("miss_v_hold", {128'd0, miss_v}, 129'd1);
        chk("miss_tag_hold", {121'd0, miss_tag}, {121'd0, t});
      end
      miss_ready = 1'b1;
      @(posedge clk); #1;
      miss_ready = 1'b0;
      chk("wait_fill_state", {127'd0, state_dbg}, 129'd2);
      @(posedge clk); #1;
      fill_v = 1'b1; fill_data = d; replace_which = repl; inval = inv_fill;
      @(posedge clk); #1;
      fill_v = 1'b0; inval = 1'b0; replace_which = 2'd0;
      chk("fill_resp_latency", {128'd0, resp_v}, 129'd1);
    end
    for (int i = 0; i < rstall; i++) begin
      @(posedge clk); #1;
      chk("resp_v_hold", {128'd0, resp_v}, 129'd1);
      chk("resp_data_hold", {1'b0, resp_data}, {1'b0, d});
      chk("req_ready_stall", {128'd0, req_ready}, 129'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("req_ready_after_resp", {128'd0, req_ready}, 129'd1);
    chk("resp_v_drop", {128'd0, resp_v}, 129'd0);
  endtask

  task automatic pulse_inval();
    inval = 1'b1;
    @(posedge clk); #1;
    inval = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2;
    chk("rst_req_ready", {128'd0, req_ready}, 129'd1);
    chk("rst_resp_v", {128'd0, resp_v}, 129'd0);
    chk("rst_miss_v", {128'd0, miss_v}, 129'd0);
    chk("rst_lru", {125'd0, lru_hit_v, lru_fill_v, lru_hit_way ^ lru_fill_way}, 129'd0);
    chk("rst_resp_data", {resp_hit, resp_data}, 129'd0);
    chk("rst_miss_tag", {121'd0, miss_tag}, 129'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Cold miss then hit
    do_req(8'h11, 1'b0, DATA_A, 2'd0, 2'd3, 0, 0, 1'b0);
    do_req(8'h11, 1'b1, DATA_A, 2'd0, 2'd0, 0, 1, 1'b0);

    // Fill order and eviction, with handshake stalls on the first one
    pulse_inval();
    do_req(8'h01, 1'b0, mkd(8'h01), 2'd0, 2'd3, 5, 3, 1'b0);
    do_req(8'h02, 1'b0, mkd(8'h02), 2'd1, 2'd3, 0, 0, 1'b0);
    do_req(8'h03, 1'b0, mkd(8'h03), 2'd2, 2'd3, 1, 0, 1'b0);
    do_req(8'h04, 1'b0, mkd(8'h04), 2'd3, 2'd0, 0, 0, 1'b0);
    do_req(8'h05, 1'b0, mkd(8'h05), 2'd2, 2'd2, 0, 0, 1'b0);
    do_req(8'h01, 1'b1, mkd(8'h01), 2'd0, 2'd0, 0, 0, 1'b0);
    do_req(8'h02, 1'b1, mkd(8'h02), 2'd1, 2'd0, 0, 2, 1'b0);
    do_req(8'h04, 1'b1, mkd(8'h04), 2'd3, 2'd0, 0, 0, 1'b0);
    do_req(8'h03, 1'b0, mkd(8'h03), 2'd0, 2'd0, 0, 0, 1'b0);
    do_req(8'h05, 1'b1, mkd(8'h05), 2'd2, 2'd0, 0, 0, 1'b0);

    // Invalidate, refill from way 0, then invalidate during a fill
    pulse_inval();
    do_req(8'h01, 1'b0, mkd(8'h01), 2'd0, 2'd3, 0, 0, 1'b0);
    do_req(8'h02, 1'b0, mkd(8'h02), 2'd1, 2'd3, 0, 0, 1'b0);
    do_req(8'h06, 1'b0, mkd(8'h06), 2'd2, 2'd0, 0, 0, 1'b0);
    do_req(8'h07, 1'b0, mkd(8'h07), 2'd3, 2'd0, 0, 0, 1'b0);
    do_req(8'h08, 1'b0, mkd(8'h08), 2'd3, 2'd3, 0, 0, 1'b1);
    do_req(8'h08, 1'b1, mkd(8'h08), 2'd3, 2'd0, 0, 0, 1'b0);
    do_req(8'h01, 1'b0, mkd(8'h01), 2'd0, 2'd2, 0, 0, 1'b0);
    do_req(8'h02, 1'b0, mkd(8'h02), 2'd1, 2'd2, 0, 0, 1'b0);

    // Stray fill in IDLE
    fill_v = 1'b1; fill_data = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
    #1;
    chk("stray_no_lru_fill", {128'd0, lru_fill_v}, 129'd0);
    @(posedge clk); #1;
    fill_v = 1'b0;
    chk("stray_state", {127'd0, state_dbg}, 129'd0);
    chk("stray_resp_v", {128'd0, resp_v}, 129'd0);
    do_req(8'h08, 1'b1, mkd(8'h08), 2'd3, 2'd0, 0, 0, 1'b0);
    do_req(8'h01, 1'b1, mkd(8'h01), 2'd0, 2'd0, 0, 0, 1'b0);

    // Reset while waiting for a fill
    exp_miss_q.push_back(8'h09);
    req_v = 1'b1; req_tag = 8'h09;
    @(posedge clk); #1;
    req_v = 1'b0; miss_ready = 1'b1;
    @(posedge clk); #1;
    miss_ready = 1'b0;
    chk("pre_reset_wait_fill", {127'd0, state_dbg}, 129'd2);
    rst = 1'b1;
    #1;
    chk("mid_rst_req_ready", {128'd0, req_ready}, 129'd1);
    chk("mid_rst_valids", {126'd0, resp_v, miss_v, lru_hit_v | lru_fill_v}, 129'd0);
    chk("mid_rst_state", {127'd0, state_dbg}, 129'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    fill_v = 1'b1; fill_data = mkd(8'h09);
    #1;
    chk("post_rst_no_lru_fill", {128'd0, lru_fill_v}, 129'd0);
    @(posedge clk); #1;
    fill_v = 1'b0;
    chk("post_rst_resp_v", {128'd0, resp_v}, 129'd0);
    chk("post_rst_req_ready", {128'd0, req_ready}, 129'd1);
    do_req(8'h08, 1'b0, mkd(8'h08), 2'd0, 2'd3, 0, 0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("queues_drained",
        129'(exp_resp_q.size() + exp_lru_q.size() + exp_miss_q.size()), 129'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Overall time bound so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  end

endmodule
